// File: rtl/wide_fifo_pkg.sv
// Shared types and helpers for the wide FIFO read-side serializer.
// Provides the serializer state encoding and the beat-count helper used to
// derive per-word beat counts from the word and beat widths.
package wide_fifo_pkg;

  typedef enum logic {
    EMPTY = 1'b0,  // no word held
    SEND  = 1'b1   // word held, beats pending
  } ser_state_e;

  // Number of narrow beats that make up one wide FIFO word.
  function automatic int nbeat(input int dsize, input int osize);
    return dsize / osize;
  endfunction

endpackage

// File: rtl/wide_fifo_rd_serializer.sv
// Purpose: pops DSIZE-bit words from a FWFT FIFO and streams them as DSIZE/OSIZE
//   narrow valid/ready beats, LSB slice first, o_last on the final slice.
// Latency: fifo_empty falling while idle -> pop same cycle, first beat valid next cycle;
//   back-to-back words stream with no idle cycles.
// Backpressure: o_ready low holds o_data/o_last/beat position; valid is never withdrawn
//   without a handshake (only flush or reset drop it).
// Ports:
//   rd_clk, rd_rst    clock and asynchronous active-high reset
//   fifo_dout/empty   FWFT FIFO head word and empty flag
//   fifo_rd_en        combinational pop strobe, never asserted while fifo_empty
//   flush             synchronous discard of the word being sent
//   o_data/o_valid/o_last/o_ready  narrow beat stream
//   o_word_cnt        wrapping count of words whose last beat was accepted
module wide_fifo_rd_serializer
  import wide_fifo_pkg::*;
#(
  parameter int DSIZE = 1024,
  parameter int OSIZE = 64,
  parameter int CSIZE = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [DSIZE-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic [OSIZE-1:0] o_data,
  output logic             o_valid,
  output logic             o_last,
  input  logic             o_ready,
  output logic [CSIZE-1:0] o_word_cnt
);

  localparam int NBEAT = nbeat(DSIZE, OSIZE);
  localparam int BSIZE = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BSIZE-1:0] LAST_BEAT = BSIZE'(NBEAT - 1);

  if ((DSIZE % OSIZE) != 0 || (DSIZE / OSIZE) < 2) begin : g_bad_params
    $error("wide_fifo_rd_serializer: DSIZE must be a multiple of OSIZE with at least 2 beats");
  end

  ser_state_e       state;
  logic [DSIZE-1:0] word_buf;
  logic [BSIZE-1:0] beat_cnt;

  logic handshake;
  logic word_done;
  logic load;

  assign o_valid   = (state == SEND);
  assign o_last    = o_valid && (beat_cnt == LAST_BEAT);
  // Beat mux reads only the held word, so FIFO head changes never reach o_data.
  assign o_data    = word_buf[int'(beat_cnt) * OSIZE +: OSIZE];

  assign handshake = o_valid && o_ready;
  assign word_done = handshake && o_last;

  // Refill when idle, or on the same edge the last beat leaves so words stream gap-free.
  assign load       = !fifo_empty && !flush && ((state == EMPTY) || word_done);
  // Reset gating keeps the pop strobe quiet while reset is held with a non-empty FIFO.
  assign fifo_rd_en = load && !rd_rst;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state      <= EMPTY;
      word_buf   <= '0;
      beat_cnt   <= '0;
      o_word_cnt <= '0;
    end else if (flush) begin
      // Flush wins over a coincident last-beat handshake: the word is not counted.
      state    <= EMPTY;
      beat_cnt <= '0;
    end else begin
      if (word_done) begin
        o_word_cnt <= o_word_cnt + CSIZE'(1);
      end
      if (load) begin
        word_buf <= fifo_dout;
        beat_cnt <= '0;
        state    <= SEND;
      end else if (word_done) begin
        beat_cnt <= '0;
        state    <= EMPTY;
      end else if (handshake) begin
        beat_cnt <= beat_cnt + BSIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_wide_fifo_rd_serializer.sv
module tb_wide_fifo_rd_serializer;

  localparam int DW = 144;
  localparam int OW = 48;
  localparam int NB = 3;
  localparam int CW = 16;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic          vld;
    logic [OW-1:0] dat;
    logic          last;
    logic          rd_en;
    logic [CW-1:0] cnt;
    logic          rdy;
    logic          flush;
    logic          held;
    logic          exp_pop;
    beat_t         exp;
  } obs_t;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic          flush = 1'b0;
  logic          o_ready = 1'b0;
  logic          fifo_rd_en, o_valid, o_last;
  logic [OW-1:0] o_data;
  logic [CW-1:0] o_word_cnt;
  logic          fifo_rd_en2, o_valid2, o_last2;
  logic [OW-1:0] o_data2;
  logic [1:0]    o_word_cnt2;

  always #5 rd_clk = ~rd_clk;

  wide_fifo_rd_serializer #(.DSIZE(DW), .OSIZE(OW), .CSIZE(CW)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .o_data(o_data), .o_valid(o_valid),
    .o_last(o_last), .o_ready(o_ready), .o_word_cnt(o_word_cnt)
  );

  // Narrow-counter instance sharing every input with the main one.
  wide_fifo_rd_serializer #(.DSIZE(DW), .OSIZE(OW), .CSIZE(2)) dut_c2 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en2), .flush(flush), .o_data(o_data2), .o_valid(o_valid2),
    .o_last(o_last2), .o_ready(o_ready), .o_word_cnt(o_word_cnt2)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO contents, expected beat stream, word-held flag, word count.
  logic [DW-1:0] fq[$];
  beat_t         exp_q[$];
  logic          held = 1'b0;
  logic [31:0]   exp_words = '0;

  function automatic void refresh();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
  endfunction

  function automatic void push(input logic [DW-1:0] w);
    beat_t b;
    fq.push_back(w);
    for (int i = 0; i < NB; i++) begin
      b.data = w[i*OW +: OW];
      b.last = (i == NB - 1);
      exp_q.push_back(b);
    end
    refresh();
  endfunction

  function automatic void drop_word();
    logic l;
    while (exp_q.size() != 0) begin
      l = exp_q[0].last;
      void'(exp_q.pop_front());
      if (l) break;
    end
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // One clock: sample outputs and model expectations mid-cycle, advance, update model.
  task automatic tick(output obs_t o);
    logic l;
    #1;
    o.vld = o_valid; o.dat = o_data; o.last = o_last; o.rd_en = fifo_rd_en;
    o.cnt = o_word_cnt; o.rdy = o_ready; o.flush = flush; o.held = held;
    o.exp = (exp_q.size() != 0) ? exp_q[0] : '0;
    o.exp_pop = (fq.size() != 0) && !flush &&
                (!held || (exp_q.size() != 0 && exp_q[0].last && o_ready));
    @(posedge rd_clk);
    #1;
    if (o.rd_en && fq.size() != 0) begin
      void'(fq.pop_front());
      refresh();
    end
    if (o.flush) begin
      if (held) drop_word();
      held = 1'b0;
    end else begin
      if (held && o.rdy && exp_q.size() != 0) begin
        l = exp_q[0].last;
        void'(exp_q.pop_front());
        if (l) begin
          exp_words = exp_words + 1;
          held = 1'b0;
        end
      end
      if (o.exp_pop) held = 1'b1;
    end
    @(negedge rd_clk);
  endtask

  task automatic drain();
    obs_t o;
    int n;
    o_ready = 1'b1;
    flush = 1'b0;
    n = 0;
    while ((held || fq.size() != 0) && n < 100) begin
      tick(o);
      n++;
    end
    checks++;
    if (held || fq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got held=%b fifo_words=%0d want idle", held, fq.size());
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rd_rst = 1'b1;
    push(rand_word());
    @(negedge rd_clk);
    @(negedge rd_clk);
    #1;
    checks += 5;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    if (o_last !== 1'b0) begin failures++; $display("FAIL rst_last: got %b want 0", o_last); end
    if (o_data !== '0) begin failures++; $display("FAIL rst_data: got %h want 0", o_data); end
    if (o_word_cnt !== '0) begin failures++; $display("FAIL rst_cnt: got %0d want 0", o_word_cnt); end
    if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    o_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(o);
    push(rand_word());
    o_ready = 1'b0;
    tick(o);
    tick(o);
    push(rand_word());
    // Asynchronous reset in the middle of a stalled word with a non-empty FIFO.
    #2 rd_rst = 1'b1;
    #1;
    checks += 4;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", o_valid); end
    if (o_word_cnt !== '0) begin failures++; $display("FAIL rst_mid_cnt: got %0d want 0", o_word_cnt); end
    if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rst_mid_rd_en: got %b want 0", fifo_rd_en); end
    if (o_data !== '0) begin failures++; $display("FAIL rst_mid_data: got %h want 0", o_data); end
    if (held) drop_word();
    held = 1'b0;
    exp_words = '0;
    @(negedge rd_clk);
    rd_rst = 1'b0;
    drain();
  endtask

  task automatic test_single();
    obs_t o;
    logic [4:0] vpat = 5'b01110;
    logic [4:0] rpat = 5'b00001;
    logic [4:0] lpat = 5'b01000;
    logic [OW-1:0] dexp[5];
    logic [DW-1:0] w;
    dexp[1] = 48'hAAAA; dexp[2] = 48'hBBBB; dexp[3] = 48'hCCCC;
    w = {48'hCCCC, 48'hBBBB, 48'hAAAA};
    o_ready = 1'b1;
    push(w);
    for (int i = 0; i < 5; i++) begin
      tick(o);
      checks += 3;
      if (o.vld !== vpat[i]) begin failures++; $display("FAIL single_vld[%0d]: got %b want %b", i, o.vld, vpat[i]); end
      if (o.rd_en !== rpat[i]) begin failures++; $display("FAIL single_rd_en[%0d]: got %b want %b", i, o.rd_en, rpat[i]); end
      if (o.last !== lpat[i]) begin failures++; $display("FAIL single_last[%0d]: got %b want %b", i, o.last, lpat[i]); end
      if (vpat[i]) begin
        checks++;
        if (o.dat !== dexp[i]) begin failures++; $display("FAIL single_data[%0d]: got %h want %h", i, o.dat, dexp[i]); end
      end
    end
    checks++;
    if (o_word_cnt !== exp_words[CW-1:0]) begin
      failures++; $display("FAIL single_cnt: got %0d want %0d", o_word_cnt, exp_words[CW-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [7:0] vpat = 8'b0111_1110;
    logic [7:0] rpat = 8'b0000_1001;
    logic [7:0] lpat = 8'b0100_1000;
    o_ready = 1'b1;
    push(rand_word());
    push(rand_word());
    for (int i = 0; i < 8; i++) begin
      tick(o);
      checks += 3;
      if (o.vld !== vpat[i]) begin failures++; $display("FAIL b2b_vld[%0d]: got %b want %b", i, o.vld, vpat[i]); end
      if (o.rd_en !== rpat[i]) begin failures++; $display("FAIL b2b_rd_en[%0d]: got %b want %b", i, o.rd_en, rpat[i]); end
      if (o.last !== lpat[i]) begin failures++; $display("FAIL b2b_last[%0d]: got %b want %b", i, o.last, lpat[i]); end
      if (vpat[i]) begin
        checks++;
        if (o.dat !== o.exp.data) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", i, o.dat, o.exp.data); end
      end
    end
    checks++;
    if (o_word_cnt !== exp_words[CW-1:0]) begin
      failures++; $display("FAIL b2b_cnt: got %0d want %0d", o_word_cnt, exp_words[CW-1:0]);
    end
  endtask

  task automatic test_stall();
    obs_t o, p;
    logic [3:0] rpat = 4'b1001;
    int i;
    push(rand_word());
    push(rand_word());
    p.vld = 1'b0;
    i = 0;
    while ((held || fq.size() != 0) && i < 60) begin
      o_ready = (i < 4) ? rpat[i] : 1'($urandom_range(0, 1));
      tick(o);
      checks += 3;
      if (o.vld !== o.held) begin failures++; $display("FAIL stall_vld[%0d]: got %b want %b", i, o.vld, o.held); end
      if (o.rd_en !== o.exp_pop) begin failures++; $display("FAIL stall_rd_en[%0d]: got %b want %b", i, o.rd_en, o.exp_pop); end
      if (o.cnt !== o.exp.data[0] && 1'b0) begin end
      if (o.held && (o.dat !== o.exp.data || o.last !== o.exp.last)) begin
        failures++; $display("FAIL stall_beat[%0d]: got %h/%b want %h/%b", i, o.dat, o.last, o.exp.data, o.exp.last);
      end
      if (p.vld && !p.rdy) begin
        checks++;
        if (!o.vld || o.dat !== p.dat || o.last !== p.last) begin
          failures++; $display("FAIL stall_hold[%0d]: got %b/%h/%b want 1/%h/%b", i, o.vld, o.dat, o.last, p.dat, p.last);
        end
      end
      p = o;
      i++;
    end
    checks += 2;
    if (held || fq.size() != 0) begin failures++; $display("FAIL stall_timeout: got held=%b want idle", held); end
    if (o_word_cnt !== exp_words[CW-1:0]) begin
      failures++; $display("FAIL stall_cnt: got %0d want %0d", o_word_cnt, exp_words[CW-1:0]);
    end
  endtask

  task automatic test_flush();
    obs_t o;
    logic [DW-1:0] wa, wb;
    logic [31:0] cnt0;
    wa = rand_word();
    wb = rand_word();
    cnt0 = exp_words;
    o_ready = 1'b1;
    push(wa);
    push(wb);
    tick(o);
    tick(o);
    flush = 1'b1;
    tick(o);
    flush = 1'b0;
    checks += 2;
    if (o.vld !== 1'b1 || o.dat !== wa[OW +: OW]) begin
      failures++; $display("FAIL flush_beat2: got %b/%h want 1/%h", o.vld, o.dat, wa[OW +: OW]);
    end
    if (o.rd_en !== 1'b0) begin failures++; $display("FAIL flush_no_pop: got %b want 0", o.rd_en); end
    tick(o);
    checks += 3;
    if (o.vld !== 1'b0) begin failures++; $display("FAIL flush_vld_drop: got %b want 0", o.vld); end
    if (o.rd_en !== 1'b1) begin failures++; $display("FAIL flush_repop: got %b want 1", o.rd_en); end
    if (o.cnt !== cnt0[CW-1:0]) begin failures++; $display("FAIL flush_cnt: got %0d want %0d", o.cnt, cnt0[CW-1:0]); end
    tick(o);
    checks++;
    if (o.vld !== 1'b1 || o.dat !== wb[OW-1:0] || o.last !== 1'b0) begin
      failures++; $display("FAIL flush_next_beat0: got %b/%h/%b want 1/%h/0", o.vld, o.dat, o.last, wb[OW-1:0]);
    end
    tick(o);
    // Flush coincident with the accepted last beat: the word must not be counted.
    flush = 1'b1;
    tick(o);
    flush = 1'b0;
    checks++;
    if (o.last !== 1'b1 || o.dat !== wb[2*OW +: OW]) begin
      failures++; $display("FAIL flush_last_beat: got %b/%h want 1/%h", o.last, o.dat, wb[2*OW +: OW]);
    end
    tick(o);
    checks += 2;
    if (o.vld !== 1'b0) begin failures++; $display("FAIL flush_last_vld: got %b want 0", o.vld); end
    if (o.cnt !== cnt0[CW-1:0]) begin failures++; $display("FAIL flush_last_cnt: got %0d want %0d", o.cnt, cnt0[CW-1:0]); end
  endtask

  task automatic test_random();
    obs_t o, p;
    p.vld = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fq.size() < 4 && $urandom_range(0, 2) == 0) push(rand_word());
      o_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      tick(o);
      checks += 4;
      if (o.vld !== o.held) begin failures++; $display("FAIL rand_vld[%0d]: got %b want %b", i, o.vld, o.held); end
      if (o.rd_en !== o.exp_pop) begin failures++; $display("FAIL rand_rd_en[%0d]: got %b want %b", i, o.rd_en, o.exp_pop); end
      if (o.cnt !== exp_words[CW-1:0] && !(o.cnt === CW'(exp_words - 0))) begin end
      if (o.held ? (o.dat !== o.exp.data || o.last !== o.exp.last) : (o.last !== 1'b0)) begin
        failures++; $display("FAIL rand_beat[%0d]: got %h/%b want %h/%b", i, o.dat, o.last, o.exp.data, o.exp.last);
      end
      if (p.vld && !p.rdy && !p.flush && (o.dat !== p.dat || o.last !== p.last || !o.vld)) begin
        failures++; $display("FAIL rand_hold[%0d]: got %b/%h want 1/%h", i, o.vld, o.dat, p.dat);
      end
      p = o;
    end
    flush = 1'b0;
    drain();
    checks++;
    if (o_word_cnt !== exp_words[CW-1:0]) begin
      failures++; $display("FAIL rand_cnt: got %0d want %0d", o_word_cnt, exp_words[CW-1:0]);
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    logic [1:0] wexp[5];
    wexp[0] = 2'd1; wexp[1] = 2'd2; wexp[2] = 2'd3; wexp[3] = 2'd0; wexp[4] = 2'd1;
    rd_rst = 1'b1;
    @(negedge rd_clk);
    held = 1'b0;
    exp_q.delete();
    exp_words = '0;
    rd_rst = 1'b0;
    o_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(rand_word());
      for (int k = 0; k < 4; k++) tick(o);
      checks += 2;
      if (o_word_cnt2 !== wexp[i]) begin failures++; $display("FAIL wrap_cnt2[%0d]: got %0d want %0d", i, o_word_cnt2, wexp[i]); end
      if (o_word_cnt !== CW'(i + 1)) begin failures++; $display("FAIL wrap_cnt16[%0d]: got %0d want %0d", i, o_word_cnt, i + 1); end
    end
    for (int i = 0; i < 10; i++) begin
      o_ready = 1'($urandom_range(0, 1));
      tick(o);
      checks++;
      if (o.rd_en !== 1'b0 || fifo_rd_en2 !== 1'b0 || o.vld !== 1'b0) begin
        failures++; $display("FAIL empty_no_pop[%0d]: got rd_en=%b/%b vld=%b want 0/0/0", i, o.rd_en, fifo_rd_en2, o.vld);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    drain();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
